// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and preload table entry type for the run controller
package run_ctrl_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, PRELOAD, WAIT_GO, RUN, DRAIN, FINISH} state_t;
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } preload_entry_t;
endpackage

// File: rtl/run_ctrl_preload_rom.sv
// preload_rom: combinational index -> {addr,data} constant table written after the clear
module preload_rom import run_ctrl_pkg::*; #(
  parameter int IW = 8
) (
  input  logic [IW-1:0]   idx_i,
  output preload_entry_t  entry_o
);
  always_comb entry_o = idx_i == IW'(0) ? {8'd6, 8'd128} :
                        idx_i == IW'(1) ? {8'd7, 8'd252} :
                        idx_i == IW'(2) ? {8'd8, 8'd248} : '0;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: START/DONE run protocol; initialises data memory, releases the core, counts run cycles
module run_ctrl import run_ctrl_pkg::*; #(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int NUM_PRELOAD = 3,
  parameter int DRAIN_CYC   = 2,
  parameter int CW          = 16,
  parameter int MAX_CYCLES  = 60000
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  output logic          DONE,
  output logic          TIMEOUT,
  output logic          core_rst,
  input  logic          core_halt,
  output logic          mem_sel,
  output logic          init_wr_en,
  output logic [AW-1:0] init_addr,
  output logic [DW-1:0] init_wr_data,
  output logic [CW-1:0] cycle_count
);
  localparam logic [AW-1:0] PRE_LAST   = AW'(NUM_PRELOAD > 0 ? NUM_PRELOAD - 1 : 0);
  localparam logic [7:0]    DRAIN_LAST = 8'(DRAIN_CYC > 0 ? DRAIN_CYC - 1 : 0);
  localparam logic [CW-1:0] LIMIT      = CW'(MAX_CYCLES);
  state_t         state_q;
  logic [AW-1:0]  idx_q, addr_q, rom_idx;
  logic [DW-1:0]  data_q;
  logic [7:0]     drain_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, timeout_q, core_rst_q, mem_sel_q, wr_en_q;
  logic           go_clear, limit_hit;
  preload_entry_t rom_e;
  // The ROM is always addressed one entry ahead so the registered write port sees entry i in cycle i.
  always_comb begin
    cnt_d     = &cnt_q ? cnt_q : cnt_q + 1'b1;
    rom_idx   = state_q == PRELOAD ? idx_q + 1'b1 : '0;
    go_clear  = START && (state_q == IDLE || state_q == RUN || state_q == DRAIN || state_q == FINISH);
    limit_hit = MAX_CYCLES != 0 && cnt_d == LIMIT;
  end
  preload_rom #(.IW(AW)) u_rom (.idx_i(rom_idx), .entry_o(rom_e));
  always_ff @(posedge CLK)
    if (RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      drain_q    <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
      mem_sel_q  <= 1'b1;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (go_clear) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
      mem_sel_q  <= 1'b1;
      wr_en_q    <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          idx_q  <= idx_q + 1'b1;
          addr_q <= idx_q + 1'b1;
          if (&idx_q) begin
            state_q <= NUM_PRELOAD > 0 ? PRELOAD : WAIT_GO;
            wr_en_q <= NUM_PRELOAD > 0;
            addr_q  <= AW'(rom_e.addr);
            data_q  <= DW'(rom_e.data);
          end
        end
        PRELOAD: begin
          idx_q  <= idx_q + 1'b1;
          addr_q <= AW'(rom_e.addr);
          data_q <= DW'(rom_e.data);
          if (idx_q == PRE_LAST) begin
            state_q <= WAIT_GO;
            wr_en_q <= 1'b0;
          end
        end
        WAIT_GO: if (!START) begin
          state_q    <= RUN;
          core_rst_q <= 1'b0;
          mem_sel_q  <= 1'b0;
          cnt_q      <= '0;
        end
        RUN: begin
          cnt_q   <= cnt_d;
          drain_q <= '0;
          if (core_halt) begin
            state_q    <= DRAIN_CYC > 0 ? DRAIN : FINISH;
            done_q     <= DRAIN_CYC == 0;
            core_rst_q <= DRAIN_CYC == 0;
          end else if (limit_hit) begin
            state_q    <= FINISH;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            core_rst_q <= 1'b1;
          end
        end
        DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == DRAIN_LAST) begin
            state_q    <= FINISH;
            done_q     <= 1'b1;
            core_rst_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  assign DONE         = done_q;
  assign TIMEOUT      = timeout_q;
  assign core_rst     = core_rst_q;
  assign mem_sel      = mem_sel_q;
  assign init_wr_en   = wr_en_q && !RESET;
  assign init_addr    = addr_q;
  assign init_wr_data = data_q;
  assign cycle_count  = cnt_q;
endmodule
